// File: rtl/mem_access_unit.sv
// mem_access_unit: initiator side of a word-only data memory.
// Accepts load/store requests, issues word reads/writes to the DM,
// performs read-modify-write for sb/sh, and returns extended load data
// plus a misalignment flag as a one-cycle response pulse.
// Optional build macro MEM_TRACE_EN: print one trace line per DM write.
module mem_access_unit #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [31:0]       req_pc,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_wdata,
  output logic              dm_we,
  input  logic [31:0]       dm_rdata
);

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LHU = 3'b010;
  localparam logic [2:0] OP_LB  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SB  = 3'b111;

  typedef enum logic [1:0] {IDLE, LOOKUP, WRITE, RESP} state_t;

  state_t             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [ADDR_W+1:0]  addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               req_ready_q, req_ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [31:0]        rsp_rdata_q, rsp_rdata_d;
  logic               rsp_err_q, rsp_err_d;
  logic [ADDR_W-1:0]  dm_addr_q, dm_addr_d;
  logic [31:0]        dm_wdata_q, dm_wdata_d;
  logic               dm_we_q, dm_we_d;

  // Byte addresses above the DM size simply wrap, so those bits are dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

  function automatic logic misaligned(input logic [2:0] op, input logic [1:0] a);
    case (op)
      OP_LW, OP_SW:         misaligned = (a != 2'b00);
      OP_LH, OP_LHU, OP_SH: misaligned = a[0];
      default:              misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input logic [2:0] op);
    is_store = (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] op, input logic [31:0] word,
                                           input logic [1:0] a);
    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;
    shifted = word >> {a, 3'b000};
    b = shifted[7:0];
    h = a[1] ? word[31:16] : word[15:0];
    case (op)
      OP_LW:   load_ext = word;
      OP_LH:   load_ext = {{16{h[15]}}, h};
      OP_LHU:  load_ext = {16'h0000, h};
      OP_LB:   load_ext = {{24{b[7]}}, b};
      OP_LBU:  load_ext = {24'h000000, b};
      default: load_ext = 32'h0;
    endcase
  endfunction

  // Insert the store byte/half into the word just read from the DM.
  function automatic logic [31:0] merge(input logic [2:0] op, input logic [31:0] word,
                                        input logic [1:0] a, input logic [31:0] wd);
    merge = wd;
    if (op == OP_SH) begin
      merge = a[1] ? {wd[15:0], word[15:0]} : {word[31:16], wd[15:0]};
    end else if (op == OP_SB) begin
      case (a)
        2'd0:    merge = {word[31:8], wd[7:0]};
        2'd1:    merge = {word[31:16], wd[7:0], word[7:0]};
        2'd2:    merge = {word[31:24], wd[7:0], word[15:0]};
        default: merge = {wd[7:0], word[23:0]};
      endcase
    end
  endfunction

  // Next-state and next-output logic; all outputs are registered so each
  // one is set on the edge that enters the state in which it must appear.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    dm_addr_d   = dm_addr_q;
    dm_wdata_d  = dm_wdata_q;
    dm_we_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          op_d    = req_op;
          addr_d  = req_addr[ADDR_W+1:0];
          wdata_d = req_wdata;
          if (misaligned(req_op, req_addr[1:0])) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'h0;
          end else if (req_op == OP_SW) begin
            state_d    = WRITE;
            dm_addr_d  = req_addr[ADDR_W+1:2];
            dm_we_d    = 1'b1;
            dm_wdata_d = req_wdata;
          end else begin
            state_d   = LOOKUP;
            dm_addr_d = req_addr[ADDR_W+1:2];
          end
        end
      end
      LOOKUP: begin
        // dm_rdata is valid now; it is captured on the edge that ends LOOKUP.
        if (is_store(op_q)) begin
          state_d    = WRITE;
          dm_we_d    = 1'b1;
          dm_wdata_d = merge(op_q, dm_rdata, addr_q[1:0], wdata_q);
        end else begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = load_ext(op_q, dm_rdata, addr_q[1:0]);
        end
      end
      WRITE: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = 32'h0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    req_ready_d = (state_d == IDLE);
  end

  // State and output registers; async reset drops dm_we at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= 3'b000;
      addr_q      <= '0;
      wdata_q     <= 32'h0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
      dm_addr_q   <= '0;
      dm_wdata_q  <= 32'h0;
      dm_we_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      dm_addr_q   <= dm_addr_d;
      dm_wdata_q  <= dm_wdata_d;
      dm_we_q     <= dm_we_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign dm_addr   = dm_addr_q;
  assign dm_wdata  = dm_wdata_q;
  assign dm_we     = dm_we_q;

`ifdef MEM_TRACE_EN
  logic [31:0] pc_q, pc_d;

  // Capture the issuing PC with the rest of the request.
  always_comb begin
    pc_d = pc_q;
    if (state_q == IDLE && req_valid && req_ready_q) pc_d = req_pc;
  end

  // Latch the PC used by the write trace.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc_q <= 32'h0;
    else       pc_q <= pc_d;
  end

  // One trace line per DM write, showing the merged word for sb/sh.
  always_ff @(posedge clk) begin
    if (!reset && state_q == WRITE)
      $display("@%h: *%h <= %h", pc_q, {{(30-ADDR_W){1'b0}}, dm_addr_q, 2'b00}, dm_wdata_q);
  end
`else
  logic unused_pc;
  assign unused_pc = ^req_pc;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural word memory.
module tb_mem_access_unit;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [2:0]        req_op = 3'b000;
  logic [31:0]       req_addr = 32'h0;
  logic [31:0]       req_wdata = 32'h0;
  logic [31:0]       req_pc = 32'h0;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic [ADDR_W-1:0] dm_addr;
  logic [31:0]       dm_wdata;
  logic              dm_we;
  logic [31:0]       dm_rdata;

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  int checks = 0;
  int errors = 0;

  mem_access_unit #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_we(dm_we), .dm_rdata(dm_rdata)
  );

  always #5 clk = ~clk;

  assign dm_rdata = mem[dm_addr];
  always @(posedge clk) if (dm_we) mem[dm_addr] <= dm_wdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  int          lat, we_cyc, we_n;
  logic [31:0] r_data, r_err, we_data, we_addr;

  // Issue one request at a negedge, then watch up to 8 cycles after the accept edge.
  task automatic run(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clk);
    req_op = op; req_addr = addr; req_wdata = wd; req_pc = 32'h100 + addr;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = -1; we_cyc = -1; we_n = 0; r_data = 32'hX; r_err = 32'hX;
    we_data = 32'hX; we_addr = 32'hX;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (dm_we) begin
        we_n++;
        if (we_cyc < 0) begin
          we_cyc = c; we_data = dm_wdata; we_addr = 32'(dm_addr);
        end
      end
      if (rsp_valid) begin
        lat = c; r_data = rsp_rdata; r_err = 32'(rsp_err);
        break;
      end
    end
  endtask

  task automatic load(input string tag, input logic [2:0] op, input logic [31:0] addr,
                      input logic [31:0] exp);
    run(op, addr, 32'h0);
    check({tag, " lat"}, lat, 2);
    check({tag, " rdata"}, r_data, exp);
    check({tag, " err"}, r_err, 0);
    check({tag, " no_we"}, we_n, 0);
  endtask

  task automatic bad(input string tag, input logic [2:0] op, input logic [31:0] addr);
    run(op, addr, 32'hCAFEF00D);
    check({tag, " lat"}, lat, 1);
    check({tag, " err"}, r_err, 1);
    check({tag, " rdata"}, r_data, 0);
    check({tag, " no_we"}, we_n, 0);
  endtask

  int rv_n;

  initial begin
    for (int i = 0; i < (1<<ADDR_W); i++) mem[i] = 32'h0;
    repeat (2) @(negedge clk);
    check("rst req_ready", 32'(req_ready), 1);
    check("rst rsp_valid", 32'(rsp_valid), 0);
    check("rst rsp_rdata", rsp_rdata, 0);
    check("rst rsp_err", 32'(rsp_err), 0);
    check("rst dm_addr", 32'(dm_addr), 0);
    check("rst dm_wdata", dm_wdata, 0);
    check("rst dm_we", 32'(dm_we), 0);
    reset = 1'b0;

    // sw: write in cycle 1, response in cycle 2
    run(3'b101, 32'h10, 32'hDEADBEEF);
    check("sw we_cyc", we_cyc, 1);
    check("sw we_n", we_n, 1);
    check("sw dm_addr", we_addr, 4);
    check("sw dm_wdata", we_data, 32'hDEADBEEF);
    check("sw lat", lat, 2);
    check("sw err", r_err, 0);

    load("lb13", 3'b011, 32'h13, 32'hFFFFFFDE);
    load("lbu13", 3'b100, 32'h13, 32'h000000DE);
    load("lh10", 3'b001, 32'h10, 32'hFFFFBEEF);
    load("lhu12", 3'b010, 32'h12, 32'h0000DEAD);
    load("lw10", 3'b000, 32'h10, 32'hDEADBEEF);

    // Misaligned right after a load so rdata must be forced to 0
    bad("lw02", 3'b000, 32'h02);
    bad("sh01", 3'b110, 32'h01);
    bad("sw03", 3'b101, 32'h03);

    // sb/sh read-modify-write: write in cycle 2, response in cycle 3
    run(3'b111, 32'h11, 32'hFFFFFF55);
    check("sb we_cyc", we_cyc, 2);
    check("sb dm_addr", we_addr, 4);
    check("sb dm_wdata", we_data, 32'hDEAD55EF);
    check("sb lat", lat, 3);
    run(3'b110, 32'h12, 32'hFFFF1234);
    check("sh we_cyc", we_cyc, 2);
    check("sh dm_wdata", we_data, 32'h123455EF);
    check("sh lat", lat, 3);
    check("sh mem4", mem[4], 32'h123455EF);

    // Upper address bits wrap: 0x1014 maps to word 5
    run(3'b101, 32'h0000_1014, 32'h0000007F);
    check("wrap dm_addr", we_addr, 5);
    check("wrap mem5", mem[5], 32'h0000007F);
    load("lb14pos", 3'b011, 32'h14, 32'h0000007F);
    load("lh16", 3'b001, 32'h16, 32'h00000000);

    // Async reset during the WRITE cycle of an sb
    @(negedge clk);
    req_op = 3'b111; req_addr = 32'h10; req_wdata = 32'h000000AA; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rstw dm_we_before", 32'(dm_we), 1);
    #2 reset = 1'b1;
    #1 check("rstw dm_we_async", 32'(dm_we), 0);
    @(negedge clk);
    check("rstw req_ready", 32'(req_ready), 1);
    check("rstw mem4", mem[4], 32'h123455EF);
    reset = 1'b0;
    rv_n = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (rsp_valid) rv_n++;
    end
    check("rstw no_rsp", rv_n, 0);

    // Held req_valid: second request accepted only in the cycle after RESP
    @(negedge clk);
    req_op = 3'b000; req_addr = 32'h10; req_valid = 1'b1;
    @(posedge clk);
    #1 req_op = 3'b100; req_addr = 32'h11;
    @(negedge clk);
    check("hold c1 ready", 32'(req_ready), 0);
    @(negedge clk);
    check("hold c2 ready", 32'(req_ready), 0);
    check("hold c2 rsp_valid", 32'(rsp_valid), 1);
    check("hold c2 rdata", rsp_rdata, 32'h123455EF);
    @(negedge clk);
    check("hold c3 ready", 32'(req_ready), 1);
    check("hold c3 rsp_valid", 32'(rsp_valid), 0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = -1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = c; r_data = rsp_rdata;
        break;
      end
    end
    check("hold 2nd lat", lat, 2);
    check("hold 2nd rdata", r_data, 32'h00000055);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator side of the word-only data memory interface.
- Takes load/store requests from the MEM pipeline stage.
- Issues word-address reads and writes to the DM, and performs read-modify-write for sb/sh, because the DM only writes whole words.
- Returns sign/zero-extended load data and a misalignment error flag through a valid/ready handshake.

Parameters:
- ADDR_W, 10, DM word-address width; byte address space is 2^(ADDR_W+2) bytes.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request (high only in IDLE)
- req_op  in  3  000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu, 101 sw, 110 sh, 111 sb
- req_addr  in  32  byte address
- req_wdata  in  32  store data; low byte/half used for sb/sh
- req_pc  in  32  PC of the issuing instruction (trace only)
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  misaligned access, valid with rsp_valid
- dm_addr  out  ADDR_W  DM word address
- dm_wdata  out  32  DM write data
- dm_we  out  1  DM write enable
- dm_rdata  in  32  DM read data; sampled one cycle after dm_addr is presented

Behaviour:
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, dm_addr=0, dm_wdata=0, dm_we=0, all latched request registers=0.
- Reset is asynchronous. If it asserts mid-transaction: dm_we drops immediately, the transaction is dropped, and no response is issued.
- Accept: req_valid & req_ready at a rising edge latches op, addr, wdata and pc.
- Alignment check on accept:
  - lw/sw: error if addr[1:0]!=0.
  - lh/lhu/sh: error if addr[0]!=0.
  - Misaligned requests go to RESP with rsp_err=1 and rsp_rdata=0; no DM access, dm_we never asserted.
- States:
  - IDLE: req_ready=1; dm_we=0. On accept: aligned sw -> WRITE; other aligned ops -> LOOKUP; misaligned -> RESP.
  - LOOKUP: dm_addr=addr[ADDR_W+1:2], dm_we=0; dm_rdata registered into word_q at the end of the cycle. Loads -> RESP; sb/sh -> WRITE.
  - WRITE: dm_we=1 for exactly one cycle, then -> RESP.
    - sw: dm_wdata = wdata.
    - sh: word_q with half addr[1] replaced by wdata[15:0].
    - sb: word_q with byte addr[1:0] replaced by wdata[7:0].
  - RESP: rsp_valid=1 for one cycle, then -> IDLE. rsp_rdata and rsp_err hold until the next RESP.
- Latency, counting the accept edge as cycle 0, rsp_valid is high in:
  - loads and sw: cycle 2
  - sb/sh: cycle 3
  - errors: cycle 1
- Throughput: a new request is accepted no earlier than the cycle after RESP.
- Byte order is little-endian: byte k occupies bits 8k+7:8k; half h occupies bits 16h+15:16h.
- Extension: lb/lh sign-extend; lbu/lhu zero-extend.
- Address bits above ADDR_W+1 are ignored and wrap modulo the DM size.
- dm_addr holds its last value in IDLE and RESP.
- req_valid is ignored outside IDLE.

Optional Feature:
- Macro: MEM_TRACE_EN.
- Defined: in every WRITE cycle, print "@%h: *%h <= %h" with the latched pc, the byte address {addr[31:ADDR_W+2] cleared, word address, 2'b00}, and dm_wdata. The value printed is the merged word for sb/sh.
- Undefined: no display; req_pc is unused and its latch is optimised away.

Test Plan:
- Reset, then sw addr 0x10 data 0xDEADBEEF -> dm_we=1 in cycle 1 with dm_addr=4 and dm_wdata=0xDEADBEEF; rsp_valid in cycle 2 with rsp_err=0.
- With word 4 = 0xDEADBEEF: lb 0x13 -> rdata 0xFFFFFFDE; lbu 0x13 -> 0x000000DE; lh 0x10 -> 0xFFFFBEEF; lhu 0x12 -> 0x0000DEAD. Each with rsp_valid in cycle 2.
- sb 0x11 data 0x55 on word 0xDEADBEEF -> dm_wdata=0xDEAD55EF in cycle 2, rsp_valid in cycle 3. Then sh 0x12 data 0x1234 -> 0x123455EF.
- lw 0x02, sh 0x01, sw 0x03 -> rsp_err=1 in cycle 1, rsp_rdata=0, dm_we never asserted.
- Assert reset during the WRITE cycle of an sb -> dm_we falls without waiting for a clock edge, no rsp_valid, req_ready=1, memory word unchanged.
- Hold req_valid=1 with a second request during LOOKUP -> it is not accepted until the cycle after RESP; with MEM_TRACE_EN, exactly one trace line per store.
